deconv_col_feeder: RTL and testbench

Column source for the deconvolution operator. It buffers one kernel channel (WEIGHT_SIZE weight columns) and one feature-map channel (FEATURE_SIZE feature columns) from an upstream BRAM loader. It then replays them to the operator with load strobes, stepping forward on the operator's per-column and per-channel control pulses. It drives the operator's i_weight_col/i_enable_loadw and i_feature_map_col/i_enable_loadip inputs, and consumes its en_prcs_new_wcoln, en_fifo_loop and en_prcs_new_chnl outputs.

---
 rtl/deconv_col_feeder.sv | 182 ++++++++++++++++++
 tb/tb_deconv_col_feeder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/deconv_col_feeder.sv
// Column source for the deconvolution operator: buffers one weight channel and one feature channel, then replays them.
// Latency: first loadip one cycle after the final fill handshake; loadw one cycle after loadip or after a column ack.
// Backpressure: readies drop per buffer once it is full or while replaying; operator paces replay via ack/loop/flush pulses.
module deconv_col_feeder #(
  parameter int WEIGHT_SIZE  = 5,
  parameter int BIT_WIDTH    = 8,
  parameter int FEATURE_SIZE = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [BIT_WIDTH*WEIGHT_SIZE-1:0]  i_wcol_data,
  input  logic                              i_wcol_valid,
  output logic                              o_wcol_ready,
  input  logic [BIT_WIDTH*FEATURE_SIZE-1:0] i_fcol_data,
  input  logic                              i_fcol_valid,
  output logic                              o_fcol_ready,
  output logic [BIT_WIDTH*WEIGHT_SIZE-1:0]  o_weight_col,
  output logic                              o_enable_loadw,
  output logic [BIT_WIDTH*FEATURE_SIZE-1:0] o_feature_map_col,
  output logic                              o_enable_loadip,
  input  logic                              i_prcs_new_wcoln,
  input  logic                              i_fifo_loop,
  input  logic                              i_prcs_new_chnl,
  output logic                              o_chnl_done,
  output logic                              o_busy
);

  localparam int WW  = BIT_WIDTH * WEIGHT_SIZE;
  localparam int FW  = BIT_WIDTH * FEATURE_SIZE;
  localparam int WCW = $clog2(WEIGHT_SIZE + 1);
  localparam int FCW = $clog2(FEATURE_SIZE + 1);
  localparam int WPW = (WEIGHT_SIZE > 1) ? $clog2(WEIGHT_SIZE) : 1;
  localparam int FPW = (FEATURE_SIZE > 1) ? $clog2(FEATURE_SIZE) : 1;

  localparam logic [WCW-1:0] WCNT_FULL = WCW'(WEIGHT_SIZE);
  localparam logic [FCW-1:0] FCNT_FULL = FCW'(FEATURE_SIZE);
  localparam logic [WPW-1:0] WRD_LAST  = WPW'(WEIGHT_SIZE - 1);
  localparam logic [FPW-1:0] FRD_LAST  = FPW'(FEATURE_SIZE - 1);

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_FEED_IP = 3'd1,
    S_FEED_W  = 3'd2,
    S_WAIT    = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [WCW-1:0] r_wcnt;
  logic [WCW-1:0] w_wcnt_nxt;
  logic [FCW-1:0] r_fcnt;
  logic [FCW-1:0] w_fcnt_nxt;
  logic [WPW-1:0] r_wrd;
  logic [WPW-1:0] w_wrd_nxt;
  logic [FPW-1:0] r_frd;
  logic [FPW-1:0] w_frd_nxt;
  logic           w_done_nxt;
  logic           w_wr_w;
  logic           w_wr_f;
  logic [WW-1:0]  w_wcol_sel;
  logic [FW-1:0]  w_fcol_sel;

  logic [WW-1:0]  r_wbuf [WEIGHT_SIZE];
  logic [FW-1:0]  r_fbuf [FEATURE_SIZE];

  logic [WW-1:0]  r_weight_col;
  logic [FW-1:0]  r_feature_map_col;
  logic           r_enable_loadw;
  logic           r_enable_loadip;
  logic           r_chnl_done;

  assign o_wcol_ready      = (r_state == S_LOAD) && (r_wcnt < WCNT_FULL);
  assign o_fcol_ready      = (r_state == S_LOAD) && (r_fcnt < FCNT_FULL);
  assign o_busy            = (r_state != S_LOAD);
  assign o_weight_col      = r_weight_col;
  assign o_feature_map_col = r_feature_map_col;
  assign o_enable_loadw    = r_enable_loadw;
  assign o_enable_loadip   = r_enable_loadip;
  assign o_chnl_done       = r_chnl_done;

  assign w_wr_w = i_wcol_valid && o_wcol_ready;
  assign w_wr_f = i_fcol_valid && o_fcol_ready;

  // Weight columns only leave the buffer after loading has finished, so no bypass is needed.
  assign w_wcol_sel = r_wbuf[w_wrd_nxt];
  // The first feature column can be issued on the same edge it is written when the buffer is one column deep.
  assign w_fcol_sel = (w_wr_f && (r_fcnt[FPW-1:0] == w_frd_nxt)) ? i_fcol_data : r_fbuf[w_frd_nxt];

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_LOAD;
    else          r_state <= w_next_state;
  end

  // Next state; fill detection uses post-write counts so loadip follows the final handshake by one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_LOAD: begin
        if ((w_wcnt_nxt == WCNT_FULL) && (w_fcnt_nxt == FCNT_FULL)) w_next_state = S_FEED_IP;
      end
      S_FEED_IP: w_next_state = S_FEED_W;
      S_FEED_W:  w_next_state = S_WAIT;
      S_WAIT: begin
        if (i_prcs_new_wcoln) begin
          if (r_wrd != WRD_LAST)      w_next_state = S_FEED_W;
          else if (r_frd != FRD_LAST) w_next_state = S_FEED_IP;
          else                        w_next_state = S_HOLD;
        end else if (i_fifo_loop) begin
          w_next_state = S_FEED_W;
        end
      end
      S_HOLD:  w_next_state = S_HOLD;
      default: w_next_state = S_LOAD;
    endcase
    if ((r_state != S_LOAD) && i_prcs_new_chnl) w_next_state = S_LOAD;
  end

  // Output-side comb: counter/pointer advance and the channel-done decision; a flush clears everything.
  always_comb begin
    w_wcnt_nxt = r_wcnt;
    w_fcnt_nxt = r_fcnt;
    w_wrd_nxt  = r_wrd;
    w_frd_nxt  = r_frd;
    w_done_nxt = 1'b0;
    if (w_wr_w) w_wcnt_nxt = r_wcnt + WCW'(1);
    if (w_wr_f) w_fcnt_nxt = r_fcnt + FCW'(1);
    if ((r_state == S_WAIT) && !i_prcs_new_chnl) begin
      if (i_prcs_new_wcoln) begin
        if (r_wrd != WRD_LAST) begin
          w_wrd_nxt = r_wrd + WPW'(1);
        end else if (r_frd != FRD_LAST) begin
          w_wrd_nxt = '0;
          w_frd_nxt = r_frd + FPW'(1);
        end else begin
          w_done_nxt = 1'b1;
        end
      end else if (i_fifo_loop) begin
        w_wrd_nxt = '0;
      end
    end
    if ((r_state != S_LOAD) && i_prcs_new_chnl) begin
      w_wcnt_nxt = '0;
      w_fcnt_nxt = '0;
      w_wrd_nxt  = '0;
      w_frd_nxt  = '0;
    end
  end

  // Counters, pointers and registered operator-facing strobes/data (strobe on entry to a feed state).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wcnt            <= '0;
      r_fcnt            <= '0;
      r_wrd             <= '0;
      r_frd             <= '0;
      r_weight_col      <= '0;
      r_feature_map_col <= '0;
      r_enable_loadw    <= 1'b0;
      r_enable_loadip   <= 1'b0;
      r_chnl_done       <= 1'b0;
    end else begin
      r_wcnt          <= w_wcnt_nxt;
      r_fcnt          <= w_fcnt_nxt;
      r_wrd           <= w_wrd_nxt;
      r_frd           <= w_frd_nxt;
      r_enable_loadip <= (w_next_state == S_FEED_IP);
      r_enable_loadw  <= (w_next_state == S_FEED_W);
      r_chnl_done     <= w_done_nxt;
      if (w_next_state == S_FEED_IP) r_feature_map_col <= w_fcol_sel;
      if (w_next_state == S_FEED_W)  r_weight_col      <= w_wcol_sel;
    end
  end

  // Column buffers; contents are don't-care after reset, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_w) r_wbuf[r_wcnt[WPW-1:0]] <= i_wcol_data;
    if (w_wr_f) r_fbuf[r_fcnt[FPW-1:0]] <= i_fcol_data;
  end

endmodule

// File: tb/tb_deconv_col_feeder.sv
// Bench for deconv_col_feeder: directed channel scenarios plus randomized traffic, all outputs compared every cycle
// against a column-pair-index model (pair p -> feature p/K, weight p%K).
// Inputs change on the falling edge; the model advances on the rising edge; outputs are compared on the falling edge.
module tb_deconv_col_feeder;
  localparam int K  = 5;
  localparam int BW = 8;
  localparam int F  = 8;
  localparam int WW = K * BW;
  localparam int FW = F * BW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n  = 1'b0;
  logic [WW-1:0] wdata  = '0;
  logic          wvalid = 1'b0;
  logic [FW-1:0] fdata  = '0;
  logic          fvalid = 1'b0;
  logic          wcoln  = 1'b0;
  logic          loop   = 1'b0;
  logic          nchnl  = 1'b0;
  logic          wready, fready, loadw, loadip, done, busy;
  logic [WW-1:0] wcol;
  logic [FW-1:0] fcol;

  deconv_col_feeder #(.WEIGHT_SIZE(K), .BIT_WIDTH(BW), .FEATURE_SIZE(F)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wcol_data(wdata), .i_wcol_valid(wvalid), .o_wcol_ready(wready),
    .i_fcol_data(fdata), .i_fcol_valid(fvalid), .o_fcol_ready(fready),
    .o_weight_col(wcol), .o_enable_loadw(loadw),
    .o_feature_map_col(fcol), .o_enable_loadip(loadip),
    .i_prcs_new_wcoln(wcoln), .i_fifo_loop(loop), .i_prcs_new_chnl(nchnl),
    .o_chnl_done(done), .o_busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] rep_w(input logic [7:0] b);
    rep_w = {K{b}};
  endfunction

  function automatic logic [FW-1:0] rep_f(input logic [7:0] b);
    rep_f = {F{b}};
  endfunction

  // ---------------- behavioural model ----------------
  typedef enum {M_LOAD, M_ISSUE, M_HOLD} mphase_t;
  mphase_t       m_phase = M_LOAD;
  int            m_wn = 0, m_fn = 0, m_p = 0;
  bit            m_pend_w = 0, m_arm = 0, m_ackok = 0;
  logic [WW-1:0] m_wbuf [K];
  logic [FW-1:0] m_fbuf [F];
  bit            e_ip = 0, e_w = 0, e_done = 0;
  logic [WW-1:0] e_wdat = '0;
  logic [FW-1:0] e_fdat = '0;

  always @(posedge clk) begin
    e_ip = 0; e_w = 0; e_done = 0;
    if (!rst_n) begin
      m_phase = M_LOAD; m_wn = 0; m_fn = 0; m_p = 0;
      m_pend_w = 0; m_arm = 0; m_ackok = 0; e_wdat = '0; e_fdat = '0;
    end else if (m_phase != M_LOAD && nchnl) begin
      m_phase = M_LOAD; m_wn = 0; m_fn = 0; m_p = 0;
      m_pend_w = 0; m_arm = 0; m_ackok = 0;
    end else if (m_phase == M_LOAD) begin
      if (wvalid && m_wn < K) begin m_wbuf[m_wn] = wdata; m_wn++; end
      if (fvalid && m_fn < F) begin m_fbuf[m_fn] = fdata; m_fn++; end
      if (m_wn == K && m_fn == F) begin
        m_phase = M_ISSUE; m_p = 0; e_ip = 1; e_fdat = m_fbuf[0]; m_pend_w = 1;
      end
    end else if (m_phase == M_ISSUE) begin
      if (m_pend_w) begin
        m_pend_w = 0; e_w = 1; e_wdat = m_wbuf[m_p % K]; m_arm = 1;
      end else if (m_arm) begin
        m_arm = 0; m_ackok = 1;             // loadw cycle itself does not accept an ack
      end else if (m_ackok && (wcoln || loop)) begin
        m_ackok = 0;
        if (wcoln) begin
          m_p++;
          if (m_p == F * K) begin
            e_done = 1; m_phase = M_HOLD;
          end else if (m_p % K == 0) begin
            e_ip = 1; e_fdat = m_fbuf[m_p / K]; m_pend_w = 1;
          end else begin
            e_w = 1; e_wdat = m_wbuf[m_p % K]; m_arm = 1;
          end
        end else begin
          m_p = (m_p / K) * K;
          e_w = 1; e_wdat = m_wbuf[0]; m_arm = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("loadip",      64'(loadip), 64'(e_ip));
    chk("loadw",       64'(loadw),  64'(e_w));
    chk("chnl_done",   64'(done),   64'(e_done));
    chk("busy",        64'(busy),   64'(m_phase != M_LOAD));
    chk("wcol_ready",  64'(wready), 64'(m_phase == M_LOAD && m_wn < K));
    chk("fcol_ready",  64'(fready), 64'(m_phase == M_LOAD && m_fn < F));
    chk("weight_col",  64'(wcol),   64'(e_wdat));
    chk("feature_col", 64'(fcol),   64'(e_fdat));
  end

  // ---------------- stimulus ----------------
  task automatic fill();
    for (int i = 0; i < 8; i++) begin
      wvalid = 1'b1;
      wdata  = (i < K) ? rep_w(8'h11 + 8'(i)) : rep_w(8'hFF);
      fvalid = 1'b1;
      fdata  = rep_f(8'h21 + 8'(i));
      @(negedge clk);
    end
    wvalid = 1'b0;
    fvalid = 1'b0;
  endtask

  // Acks each loadw 3 cycles later; loop_at/flush_at replace the ack of that loadw number.
  task automatic feed(input int loop_at, input int flush_at, input int ncyc,
                      output int nip, output int nw, output int nd,
                      output int ack_c, output int done_c);
    int cd;
    cd = 0; nip = 0; nw = 0; nd = 0; ack_c = -100; done_c = -100;
    for (int c = 0; c < ncyc; c++) begin
      if (loadip) nip++;
      if (loadw) begin
        nw++;
        cd = 4;
        if (nw == 1) chk("first_wcol_11", 64'(wcol), 64'(rep_w(8'h11)));
        if (loop_at == 0 && nw % 5 == 0) chk("wcol4_is_15", 64'(wcol), 64'(rep_w(8'h15)));
        if (loop_at > 0 && nw == loop_at + 1) chk("loop_wcol0", 64'(wcol), 64'(rep_w(8'h11)));
      end
      if (done) begin nd++; done_c = c; end
      wcoln = 1'b0; loop = 1'b0; nchnl = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          ack_c = c;
          if (nw == loop_at)       loop  = 1'b1;
          else if (nw == flush_at) begin nchnl = 1'b1; wcoln = 1'b1; end
          else                     wcoln = 1'b1;
        end
      end
      @(negedge clk);
    end
    wcoln = 1'b0; loop = 1'b0; nchnl = 1'b0;
  endtask

  initial begin
    int nip, nw, nd, ack_c, done_c, flush_cd;
    logic [63:0] r64;

    repeat (3) @(negedge clk);
    chk("rst_wready", 64'(wready), 64'd1);
    chk("rst_fready", 64'(fready), 64'd1);
    chk("rst_busy",   64'(busy),   64'd0);
    rst_n = 1'b1;

    // Full channel: simultaneous fill, extra weight writes ignored, every column acked.
    fill();
    chk("fill_loadip", 64'(loadip), 64'd1);
    chk("fill_fcol21", 64'(fcol),   64'(rep_f(8'h21)));
    wvalid = 1'b1;
    wdata  = rep_w(8'hFF);
    feed(0, 0, 220, nip, nw, nd, ack_c, done_c);
    wvalid = 1'b0;
    chk("n_loadip", 64'(nip), 64'd8);
    chk("n_loadw",  64'(nw),  64'd40);
    chk("n_done",   64'(nd),  64'd1);
    chk("done_lat", 64'(done_c - ack_c), 64'd1);
    chk("hold_busy", 64'(busy), 64'd1);
    nchnl = 1'b1;
    @(negedge clk);
    nchnl = 1'b0;
    chk("flush_wready", 64'(wready), 64'd1);
    chk("flush_busy",   64'(busy),   64'd0);

    // Rewind at weight column 2, then flush together with an ack after the 12th loadw.
    fill();
    feed(3, 12, 90, nip, nw, nd, ack_c, done_c);
    chk("lf_loadip", 64'(nip), 64'd2);
    chk("lf_loadw",  64'(nw),  64'd12);
    chk("lf_done",   64'(nd),  64'd0);
    chk("lf_wready", 64'(wready), 64'd1);
    chk("lf_fready", 64'(fready), 64'd1);

    // Reset while waiting for an ack.
    fill();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_loadw", 64'(loadw),  64'd0);
    chk("mid_rst_wcol",  64'(wcol),   64'd0);
    chk("mid_rst_fcol",  64'(fcol),   64'd0);
    chk("mid_rst_ready", 64'(wready & fready), 64'd1);
    chk("mid_rst_busy",  64'(busy),   64'd0);
    rst_n = 1'b1;

    // Randomized traffic; the per-cycle compare does the checking.
    flush_cd = 0;
    for (int c = 0; c < 6000; c++) begin
      r64    = {$urandom(), $urandom()};
      wdata  = r64[WW-1:0];
      wvalid = 1'($urandom_range(0, 1));
      r64    = {$urandom(), $urandom()};
      fdata  = r64[FW-1:0];
      fvalid = 1'($urandom_range(0, 1));
      wcoln  = ($urandom_range(0, 3) == 0);
      loop   = ($urandom_range(0, 19) == 0);
      nchnl  = ($urandom_range(0, 399) == 0);
      if (flush_cd > 0) begin
        flush_cd--;
        if (flush_cd == 0) nchnl = 1'b1;
      end
      rst_n = ($urandom_range(0, 1499) != 0);
      @(negedge clk);
      if (done) flush_cd = 3;
    end
    rst_n = 1'b1; wvalid = 1'b0; fvalid = 1'b0;
    wcoln = 1'b0; loop = 1'b0; nchnl = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
